axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_mem_responder_pkg.sv | 23 ++
 rtl/axi_mem_responder_lfsr16.sv | 34 +++
 rtl/axi_mem_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_responder_pkg.sv
// axi_mem_responder_pkg
// Shared types and constants for the HBM-channel AXI4 memory responder:
// write/read FSM state encodings and the stall-LFSR seed and tap mask.
// The LFSR constants are only used when AXI_RESP_STALL_EN is defined.

package axi_mem_responder_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axi_mem_responder_lfsr16.sv
// lfsr16
// 16-bit Fibonacci LFSR used to inject pseudo-random ready stalls into the
// memory responder. Advances on every clock; reloads the seed on reset.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   q     : current LFSR state

module lfsr16
    import axi_mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder
// AXI4 slave end of one HBM channel backed by a behavioural byte-enabled
// memory. INCR bursts only; bursts wrap modulo MEM_DEPTH words. Independent
// write and read FSMs run concurrently.
//
// Optional build macro: AXI_RESP_STALL_EN compiles in an lfsr16 instance
// that randomly withholds awready/wready/arready and the start of rvalid.
//
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   aw* (valid/ready/addr/len): write address channel
//   w*  (valid/ready/data/strb/last): write data channel
//   bvalid/bready            : write response channel
//   ar* (valid/ready/addr/len): read address channel
//   r*  (valid/ready/data/last): read data channel
//   proto_err                : sticky flag, wlast disagreed with awlen
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready=1, waiting for a write address
//   W_DATA | wready=1, accepting awlen+1 beats
//   W_RESP | bvalid=1, waiting for bready
// Read FSM
//   state   | meaning
//   R_IDLE  | arready=1, waiting for a read address
//   R_BURST | rvalid=1, presenting arlen+1 beats

module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [7:0]                awlen,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                arlen,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rlast,
    output logic                      proto_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    // Address readies stay low until the first edge after reset releases.
    logic run_q;
    logic stall;

`ifdef AXI_RESP_STALL_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr_bits;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign stall            = (lfsr_q[1:0] == 2'b00);
    assign unused_lfsr_bits = ^lfsr_q[15:2];
`else
    assign stall = 1'b0;
`endif

    // Word index: byte address dropped to word granularity, modulo depth.
    logic [IDX_W-1:0] aw_index;
    logic [IDX_W-1:0] ar_index;
    logic             unused_addr_bits;

    assign aw_index = awaddr[OFF_W +: IDX_W];
    assign ar_index = araddr[OFF_W +: IDX_W];
    assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:OFF_W+IDX_W], awaddr[OFF_W-1:0],
                                araddr[ADDR_WIDTH-1:OFF_W+IDX_W], araddr[OFF_W-1:0]};

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write path ----------------
    w_state_e         w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]       w_len_q, w_len_d;
    logic [7:0]       w_beat_q, w_beat_d;
    logic             proto_err_q, proto_err_d;
    logic             aw_hs;
    logic             w_hs;
    logic             w_last_beat;
    logic [IDX_W-1:0] mem_waddr;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign w_last_beat = (w_beat_q == w_len_q);
    assign mem_waddr   = w_idx_q + IDX_W'(w_beat_q);

    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_beat_d    = w_beat_q;
        proto_err_d = proto_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    w_idx_d   = aw_index;
                    w_len_d   = awlen;
                    w_beat_d  = '0;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // Burst length follows awlen; wlast only feeds the error flag.
                    if (wlast != w_last_beat) begin
                        proto_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready   = (w_state_q == W_IDLE) && run_q && !stall;
        wready    = (w_state_q == W_DATA) && !stall;
        bvalid    = (w_state_q == W_RESP);
        proto_err = proto_err_q;
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[mem_waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    // rdata is registered from the array at the edge that accepts the
    // address or the previous beat, so a same-cycle write is not seen and
    // the presented beat stays frozen while rready is low.
    r_state_e              r_state_q, r_state_d;
    logic [IDX_W-1:0]      r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_beat_q, r_beat_d;
    logic [7:0]            r_beat_nxt;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rlast_q, rlast_d;
    logic                  r_held_q, r_held_d;
    logic                  ar_hs;
    logic                  r_hs;

    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;
    assign r_beat_nxt = r_beat_q + 8'd1;

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        // Once a beat is shown it must stay valid until taken, even under stall.
        r_held_d  = rvalid && !rready;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_BURST;
                    r_idx_d   = ar_index;
                    r_len_d   = arlen;
                    r_beat_d  = '0;
                    rdata_d   = mem[ar_index];
                    rlast_d   = (arlen == 8'd0);
                end
            end
            R_BURST: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        r_beat_d = r_beat_nxt;
                        rdata_d  = mem[r_idx_q + IDX_W'(r_beat_nxt)];
                        rlast_d  = (r_beat_nxt == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state_q == R_IDLE) && run_q && !stall;
        rvalid  = (r_state_q == R_BURST) && (r_held_q || !stall);
        rdata   = rdata_q;
        rlast   = rlast_q;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q       <= 1'b0;
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_len_q     <= '0;
            w_beat_q    <= '0;
            proto_err_q <= 1'b0;
            r_state_q   <= R_IDLE;
            r_idx_q     <= '0;
            r_len_q     <= '0;
            r_beat_q    <= '0;
            rdata_q     <= '0;
            rlast_q     <= 1'b0;
            r_held_q    <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            w_state_q   <= w_state_d;
            w_idx_q     <= w_idx_d;
            w_len_q     <= w_len_d;
            w_beat_q    <= w_beat_d;
            proto_err_q <= proto_err_d;
            r_state_q   <= r_state_d;
            r_idx_q     <= r_idx_d;
            r_len_q     <= r_len_d;
            r_beat_q    <= r_beat_d;
            rdata_q     <= rdata_d;
            rlast_q     <= rlast_d;
            r_held_q    <= r_held_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed testbench for axi_mem_responder (default parameters).

module tb_axi_mem_responder;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          bvalid, bready;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid, rready;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          proto_err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] got_d[$];
    logic          got_l[$];

    axi_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .bvalid    (bvalid),
        .bready    (bready),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rlast     (rlast),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_aw(input logic [AW-1:0] a, input logic [7:0] l);
        int n = 0;
        awaddr = a; awlen = l; awvalid = 1'b1;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (!awready) begin
            total++; bad++;
            $display("FAIL aw_timeout awready=%0b want=1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 100) begin @(negedge clk); n++; end
        if (!wready) begin
            total++; bad++;
            $display("FAIL w_timeout wready=%0b want=1", wready);
        end
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (!bvalid) begin
            total++; bad++;
            $display("FAIL b_timeout bvalid=%0b want=1", bvalid);
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [7:0] l, output logic first_rvalid);
        int n = 0;
        got_d.delete(); got_l.delete();
        araddr = a; arlen = l; arvalid = 1'b1;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (!arready) begin
            total++; bad++;
            $display("FAIL ar_timeout arready=%0b want=1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        first_rvalid = rvalid;
        rready = 1'b1;
        n = 0;
        while (got_d.size() < int'(l) + 1 && n < 1000) begin
            if (rvalid) begin got_d.push_back(rdata); got_l.push_back(rlast); end
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        if (got_d.size() != int'(l) + 1) begin
            total++; bad++;
            $display("FAIL r_timeout beats=%0d want=%0d", got_d.size(), int'(l) + 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if (awready !== 1'b0) begin bad++; $display("FAIL rst_awready got=%0b want=0", awready); end
        total++; if (wready !== 1'b0) begin bad++; $display("FAIL rst_wready got=%0b want=0", wready); end
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%0b want=0", bvalid); end
        total++; if (arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%0b want=0", arready); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b want=0", rvalid); end
        total++; if (rlast !== 1'b0) begin bad++; $display("FAIL rst_rlast got=%0b want=0", rlast); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%0b want=0", proto_err); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL post_rst_awready got=%0b want=1", awready); end
        total++; if (arready !== 1'b1) begin bad++; $display("FAIL post_rst_arready got=%0b want=1", arready); end
    endtask

    task automatic test_write_read();
        logic          first;
        logic [DW-1:0] exp_d;
        send_aw(64'h40, 8'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL wr_early_bvalid got=%0b want=0", bvalid); end
            end
            send_w(DW'((i + 1) * 'h11), '1, i == 3);
        end
        wait_b();
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL wr_bvalid_once got=%0b want=0", bvalid); end
        read_burst(64'h40, 8'd3, first);
        total++; if (first !== 1'b1) begin bad++; $display("FAIL rd_first_rvalid got=%0b want=1", first); end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            exp_d = DW'((i + 1) * 'h11);
            total++; if (got_d[i] !== exp_d) begin bad++; $display("FAIL rd_data beat=%0d got=%h want=%h", i, got_d[i], exp_d); end
            total++; if (got_l[i] !== (i == 3)) begin bad++; $display("FAIL rd_last beat=%0d got=%0b want=%0b", i, got_l[i], i == 3); end
        end
    endtask

    task automatic test_partial_strobe();
        logic          first;
        logic [DW-1:0] exp_d;
        send_aw(64'h0, 8'd0);
        send_w('1, '1, 1'b1);
        wait_b();
        send_aw(64'h0, 8'd0);
        send_w('0, SW'(1), 1'b1);
        wait_b();
        exp_d = '1;
        exp_d[7:0] = 8'h00;
        read_burst(64'h0, 8'd0, first);
        total++; if (got_d.size() < 1 || got_d[0] !== exp_d) begin bad++; $display("FAIL partial_strobe got=%h want=%h", got_d.size() > 0 ? got_d[0] : '0, exp_d); end
        total++; if (got_l.size() < 1 || got_l[0] !== 1'b1) begin bad++; $display("FAIL single_beat_rlast got=%0b want=1", got_l.size() > 0 ? got_l[0] : 1'b0); end
    endtask

    task automatic test_wrap();
        logic          first;
        logic [DW-1:0] da, db;
        da = {64{8'hA5}};
        db = {64{8'h5B}};
        send_aw(64'(1023 * 64), 8'd1);
        send_w(da, '1, 1'b0);
        send_w(db, '1, 1'b1);
        wait_b();
        read_burst(64'(1023 * 64), 8'd0, first);
        total++; if (got_d.size() < 1 || got_d[0] !== da) begin bad++; $display("FAIL wrap_word1023 got=%h want=%h", got_d.size() > 0 ? got_d[0] : '0, da); end
        read_burst(64'h0, 8'd0, first);
        total++; if (got_d.size() < 1 || got_d[0] !== db) begin bad++; $display("FAIL wrap_word0 got=%h want=%h", got_d.size() > 0 ? got_d[0] : '0, db); end
        read_burst(64'(1023 * 64), 8'd1, first);
        total++; if (got_d.size() < 2 || got_d[1] !== db) begin bad++; $display("FAIL wrap_read_beat1 got=%h want=%h", got_d.size() > 1 ? got_d[1] : '0, db); end
    endtask

    task automatic test_proto_err();
        logic first;
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_clean got=%0b want=0", proto_err); end
        send_aw(64'h80, 8'd2);
        send_w(DW'('hC0), '1, 1'b0);
        send_w(DW'('hC1), '1, 1'b1);
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_set got=%0b want=1", proto_err); end
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL perr_early_bvalid got=%0b want=0", bvalid); end
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL perr_third_beat_wready got=%0b want=1", wready); end
        send_w(DW'('hC2), '1, 1'b1);
        wait_b();
        read_burst(64'h80, 8'd2, first);
        total++; if (got_d.size() < 3 || got_d[2] !== DW'('hC2)) begin bad++; $display("FAIL perr_beat2_data got=%h want=%h", got_d.size() > 2 ? got_d[2] : '0, DW'('hC2)); end
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%0b want=1", proto_err); end
    endtask

    task automatic test_backpressure();
        int            n;
        logic          stalled;
        logic [DW-1:0] hd;
        logic          hl;
        send_aw(64'h200, 8'd3);
        for (int i = 0; i < 4; i++) send_w(DW'('hA0 + i), '1, i == 3);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        for (int c = 0; c < 10; c++) begin
            total++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                bad++; $display("FAIL b_hold cyc=%0d bvalid=%0b awready=%0b want=1,0", c, bvalid, awready);
            end
            @(negedge clk);
        end
        wait_b();

        got_d.delete(); got_l.delete();
        araddr = 64'h200; arlen = 8'd3; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        stalled = 1'b0;
        n = 0;
        while (got_d.size() < 4 && n < 200) begin
            if (rvalid && got_d.size() == 2 && !stalled) begin
                rready = 1'b0; hd = rdata; hl = rlast; stalled = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    total++;
                    if (rvalid !== 1'b1 || rdata !== hd || rlast !== hl) begin
                        bad++; $display("FAIL r_hold cyc=%0d rvalid=%0b rdata=%h rlast=%0b want 1,%h,%0b", c, rvalid, rdata, rlast, hd, hl);
                    end
                end
                rready = 1'b1;
            end
            if (rvalid) begin got_d.push_back(rdata); got_l.push_back(rlast); end
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        total++; if (got_d.size() != 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", got_d.size()); end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            total++; if (got_d[i] !== DW'('hA0 + i)) begin bad++; $display("FAIL bp_data beat=%0d got=%h want=%h", i, got_d[i], DW'('hA0 + i)); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int   n;
        logic first;
        got_d.delete();
        araddr = 64'h40; arlen = 8'd7; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        while (!(rvalid && got_d.size() == 2) && n < 100) begin
            if (rvalid) got_d.push_back(rdata);
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        rready = 1'b0;
        #1;
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_rvalid got=%0b want=0", rvalid); end
        total++; if (rdata !== '0 || rlast !== 1'b0) begin bad++; $display("FAIL mid_rst_rdata got=%h/%0b want=0/0", rdata, rlast); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL mid_rst_proto_err got=%0b want=0", proto_err); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (arready !== 1'b1) begin bad++; $display("FAIL mid_rst_arready got=%0b want=1", arready); end
        total++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_no_resp rvalid=%0b bvalid=%0b want=0,0", rvalid, bvalid); end
        read_burst(64'h40, 8'd0, first);
        total++; if (got_d.size() < 1 || got_d[0] !== DW'('h11)) begin bad++; $display("FAIL mem_kept got=%h want=%h", got_d.size() > 0 ? got_d[0] : '0, DW'('h11)); end
    endtask

    task automatic test_long_burst();
        logic first;
        int   lasts;
        send_aw(64'h0, 8'd255);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL long_early_bvalid got=%0b want=0", bvalid); end
            end
            send_w(DW'(i + 7), '1, i == 255);
        end
        wait_b();
        read_burst(64'h0, 8'd255, first);
        lasts = 0;
        for (int i = 0; i < got_d.size(); i++) begin
            total++; if (got_d[i] !== DW'(i + 7)) begin bad++; $display("FAIL long_data beat=%0d got=%h want=%h", i, got_d[i], DW'(i + 7)); end
            if (got_l[i]) lasts++;
        end
        total++; if (got_l.size() != 256 || got_l[255] !== 1'b1 || lasts != 1) begin bad++; $display("FAIL long_rlast count=%0d want=1", lasts); end
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 1'b0; awaddr = '0; awlen = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arlen = '0;
        rready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_wrap();
        test_proto_err();
        test_backpressure();
        test_reset_mid_burst();
        test_long_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
